mem_arbiter: RTL and testbench

//  Responder end of the execution-stage memory request interface (addr/data/we/req_valid/grant/data_valid).

---
 rtl/mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / exe) arbiter in front of a single-port word-addressed memory array.
// Latency: grant 1 cycle after the request is sampled in IDLE, data_valid MEM_LATENCY+2 cycles after it.
// Backpressure: one transaction in flight; requests are held by the requester until data_valid.
//
// Ports:
//   clk / reset                  rising-edge clock, asynchronous active-low reset
//   if_req_valid/if_addr         fetch read request (byte address)
//   if_grant/if_data_valid       1-cycle pulses: accepted / read data valid
//   if_rdata                     fetch read data, registered and held
//   exe_req_valid/exe_addr/exe_we exe load/store request
//   exe_data                     bidirectional: store data in, load data out during exe_data_valid only
//   exe_grant/exe_data_valid     1-cycle pulses: accepted / load data valid or store ack
//   mem_busy                     high whenever the FSM is not IDLE
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_grant,
    output logic                  if_data_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  exe_req_valid,
    input  logic [ADDR_WIDTH-1:0] exe_addr,
    input  logic                  exe_we,
    inout  wire  [DATA_WIDTH-1:0] exe_data,
    output logic                  exe_grant,
    output logic                  exe_data_valid,
    output logic                  mem_busy
);

    localparam int IDXW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNTW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int WIDXW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Port encoding used by r_win / r_rr_last: 0 = fetch, 1 = exe
    state_t                r_state;
    state_t                w_next_state;

    logic                  r_win;
    logic                  r_we;
    logic                  r_oor;
    logic                  r_rr_last;
    logic                  r_mask_if;
    logic                  r_mask_exe;
    logic [IDXW-1:0]       r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [CNTW-1:0]       r_cnt;

    logic                  r_if_grant;
    logic                  r_exe_grant;
    logic                  r_if_dv;
    logic                  r_exe_dv;
    logic                  r_busy;
    logic                  r_exe_drv;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_if_req;
    logic                  w_exe_req;
    logic                  w_any_req;
    logic                  w_win;
    logic [WIDXW-1:0]      w_req_widx;
    logic                  w_req_oor;
    logic                  w_accept;
    logic                  w_access_done;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  w_if_grant_nxt;
    logic                  w_exe_grant_nxt;
    logic                  w_if_dv_nxt;
    logic                  w_exe_dv_nxt;
    logic                  w_busy_nxt;
    logic                  w_exe_drv_nxt;

    // Byte-offset bits are irrelevant for a word-addressed array
    logic                  w_unused;
    assign w_unused = ^{if_addr[1:0], exe_addr[1:0]};

    // The port served last is ignored for one IDLE cycle so that it can drop its request
    assign w_if_req  = if_req_valid  & ~r_mask_if;
    assign w_exe_req = exe_req_valid & ~r_mask_exe;
    assign w_any_req = w_if_req | w_exe_req;
    // Exe wins when alone, or on a tie when fetch was served last
    assign w_win     = w_exe_req & (~w_if_req | ~r_rr_last);

    assign w_req_widx    = w_win ? exe_addr[ADDR_WIDTH-1:2] : if_addr[ADDR_WIDTH-1:2];
    assign w_req_oor     = (w_req_widx >= WIDXW'(MEM_DEPTH));
    assign w_accept      = (r_state == S_IDLE) && w_any_req;
    assign w_access_done = (r_state == S_ACCESS) && (r_cnt == '0);
    assign w_rd_word     = r_oor ? '0 : r_mem[r_idx];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next_state = S_GRANT;
            S_GRANT:  w_next_state = S_ACCESS;
            S_ACCESS: if (r_cnt == '0) w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next values, registered below) ----------------
    always_comb begin
        w_if_grant_nxt  = 1'b0;
        w_exe_grant_nxt = 1'b0;
        w_if_dv_nxt     = 1'b0;
        w_exe_dv_nxt    = 1'b0;
        w_exe_drv_nxt   = 1'b0;
        w_busy_nxt      = (w_next_state != S_IDLE);
        if (w_accept) begin
            w_if_grant_nxt  = ~w_win;
            w_exe_grant_nxt = w_win;
        end
        if (w_access_done) begin
            w_if_dv_nxt   = ~r_win;
            w_exe_dv_nxt  = r_win;
            w_exe_drv_nxt = r_win & ~r_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_grant  <= 1'b0;
            r_exe_grant <= 1'b0;
            r_if_dv     <= 1'b0;
            r_exe_dv    <= 1'b0;
            r_busy      <= 1'b0;
            r_exe_drv   <= 1'b0;
        end else begin
            r_if_grant  <= w_if_grant_nxt;
            r_exe_grant <= w_exe_grant_nxt;
            r_if_dv     <= w_if_dv_nxt;
            r_exe_dv    <= w_exe_dv_nxt;
            r_busy      <= w_busy_nxt;
            r_exe_drv   <= w_exe_drv_nxt;
        end
    end

    // ---------------- Transaction datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_oor      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_if_rdata <= '0;
            r_cnt      <= '0;
            r_rr_last  <= 1'b1;
            r_mask_if  <= 1'b0;
            r_mask_exe <= 1'b0;
        end else begin
            if (w_accept) begin
                r_win   <= w_win;
                r_we    <= w_win & exe_we;
                r_oor   <= w_req_oor;
                r_idx   <= w_req_widx[IDXW-1:0];
                r_wdata <= exe_data;
            end
            if (r_state == S_GRANT) begin
                r_cnt <= CNTW'(MEM_LATENCY - 1);
            end else if (r_state == S_ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access_done && !r_we) begin
                if (r_win) r_rdata    <= w_rd_word;
                else       r_if_rdata <= w_rd_word;
            end
            if (r_state == S_RESP) begin
                r_rr_last <= r_win;
            end
            // Masks live only for the single IDLE cycle following RESP
            r_mask_if  <= (r_state == S_RESP) & ~r_win;
            r_mask_exe <= (r_state == S_RESP) &  r_win;
        end
    end

    // Array has no reset; a transaction abandoned by reset never reaches w_access_done
    always_ff @(posedge clk) begin
        if (w_access_done && r_we && !r_oor) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign if_grant       = r_if_grant;
    assign if_data_valid  = r_if_dv;
    assign if_rdata       = r_if_rdata;
    assign exe_grant      = r_exe_grant;
    assign exe_data_valid = r_exe_dv;
    assign mem_busy       = r_busy;
    assign exe_data       = r_exe_drv ? r_rdata : 'z;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-written
// sequences for reset, tie-break, alternation and reset during a store.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          if_req_valid;
    logic [AW-1:0] if_addr;
    logic          if_grant;
    logic          if_data_valid;
    logic [DW-1:0] if_rdata;
    logic          exe_req_valid;
    logic [AW-1:0] exe_addr;
    logic          exe_we;
    wire  [DW-1:0] exe_data;
    logic          exe_grant;
    logic          exe_data_valid;
    logic          mem_busy;

    logic          tb_drv;
    logic [DW-1:0] tb_wdata;
    assign exe_data = tb_drv ? tb_wdata : 'z;

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (1024),
        .MEM_LATENCY(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req_valid   (if_req_valid),
        .if_addr        (if_addr),
        .if_grant       (if_grant),
        .if_data_valid  (if_data_valid),
        .if_rdata       (if_rdata),
        .exe_req_valid  (exe_req_valid),
        .exe_addr       (exe_addr),
        .exe_we         (exe_we),
        .exe_data       (exe_data),
        .exe_grant      (exe_grant),
        .exe_data_valid (exe_data_valid),
        .mem_busy       (mem_busy)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          is_exe;
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;   // expected load data (unused for stores)
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {if_grant, exe_grant, if_data_valid, exe_data_valid, mem_busy}
    function automatic logic [4:0] obs();
        return {if_grant, exe_grant, if_data_valid, exe_data_valid, mem_busy};
    endfunction

    function automatic logic [4:0] ef(input logic e, input logic g, input logic d, input logic b);
        return {g & ~e, g & e, d & ~e, d & e, b};
    endfunction

    task automatic drop_all();
        if_req_valid  = 1'b0;
        exe_req_valid = 1'b0;
        exe_we        = 1'b0;
        tb_drv        = 1'b0;
    endtask

    // One isolated transaction starting from a mask-free IDLE.
    // Grant is expected 1 cycle later, data_valid 4 cycles later.
    task automatic run_txn(input vec_t v, input string name);
        if (v.is_exe) begin
            exe_req_valid = 1'b1;
            exe_addr      = v.addr;
            exe_we        = v.we;
            tb_drv        = v.we;
            tb_wdata      = v.wdata;
        end else begin
            if_req_valid = 1'b1;
            if_addr      = v.addr;
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("%s flags@T+%0d", name, k), obs(), ef(v.is_exe, k == 1, k == 4, 1'b1));
        end
        if (v.is_exe) chk($sformatf("%s exe_data", name), exe_data, v.we ? v.wdata : v.rdata);
        else          chk($sformatf("%s if_rdata", name), if_rdata, v.rdata);
        drop_all();
        step();
        chk($sformatf("%s flags@T+5", name), obs(), 5'b0);
        if (!v.is_exe) chk($sformatf("%s if_rdata held", name), if_rdata, v.rdata);
        step();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_1000, 32'h0BAD_0BAD, 32'h0};  // out of range, dropped
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0};  // out of range, reads 0
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0001};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h7777_8888, 32'h0};  // last word
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         32'h7777_8888};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,         32'hDEAD_BEEF};  // byte offset ignored

        reset         = 1'b0;
        if_req_valid  = 1'b0;
        if_addr       = '0;
        exe_req_valid = 1'b0;
        exe_addr      = '0;
        exe_we        = 1'b0;
        tb_drv        = 1'b0;
        tb_wdata      = '0;

        // ---- Reset held with random requests; bus must stay released ----
        tb_drv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if_req_valid  = 1'($urandom_range(0, 1));
            exe_req_valid = 1'($urandom_range(0, 1));
            exe_we        = 1'($urandom_range(0, 1));
            if_addr       = $urandom;
            exe_addr      = $urandom;
            tb_wdata      = $urandom;
            step();
            chk($sformatf("reset flags %0d", i), obs(), 5'b0);
        end
        chk("reset if_rdata", if_rdata, 32'h0);
        chk("reset exe_data released", exe_data, tb_wdata);
        drop_all();
        reset = 1'b1;
        step();

        // ---- Table of isolated transactions ----
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- Tie straight after reset: fetch first, exe right after the mask cycle ----
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        if_req_valid  = 1'b1;
        if_addr       = 32'h0;
        exe_req_valid = 1'b1;
        exe_addr      = 32'h10;
        exe_we        = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            logic [4:0] exp_f;
            step();
            case (k)
                1:       exp_f = ef(1'b0, 1'b1, 1'b0, 1'b1);
                2, 3:    exp_f = ef(1'b0, 1'b0, 1'b0, 1'b1);
                4:       exp_f = ef(1'b0, 1'b0, 1'b1, 1'b1);
                5:       exp_f = 5'b0;
                6:       exp_f = ef(1'b1, 1'b1, 1'b0, 1'b1);
                7, 8:    exp_f = ef(1'b1, 1'b0, 1'b0, 1'b1);
                default: exp_f = ef(1'b1, 1'b0, 1'b1, 1'b1);
            endcase
            chk($sformatf("tie flags@T+%0d", k), obs(), exp_f);
            if (k == 4) begin
                chk("tie if_rdata", if_rdata, 32'hA5A5_0001);
                if_req_valid = 1'b0;
            end
            if (k == 9) begin
                chk("tie exe_data", exe_data, 32'hDEAD_BEEF);
                exe_req_valid = 1'b0;
            end
        end
        step();
        step();

        // ---- Both requesting continuously: grants alternate, fetch first ----
        begin
            logic order [6];
            int   n;
            int   both;
            n    = 0;
            both = 0;
            if_req_valid  = 1'b1;
            if_addr       = 32'hFFC;
            exe_req_valid = 1'b1;
            exe_addr      = 32'h10;
            exe_we        = 1'b0;
            for (int c = 0; c < 60 && n < 6; c++) begin
                step();
                if (if_grant && exe_grant) both++;
                if (if_grant || exe_grant) begin
                    order[n] = exe_grant;
                    n++;
                end
            end
            chk("alt grant count", 64'(n), 64'd6);
            chk("alt double grant", 64'(both), 64'd0);
            for (int i = 0; i < n; i++) begin
                chk($sformatf("alt grant %0d is exe", i), 64'(order[i]), 64'(i % 2));
            end
            drop_all();
            for (int c = 0; c < 8; c++) step();
        end

        // ---- Reset during a store's ACCESS phase: array keeps the old word ----
        run_txn('{1'b1, 1'b1, 32'h20, 32'h0000_1234, 32'h0}, "pre-store");
        exe_req_valid = 1'b1;
        exe_addr      = 32'h20;
        exe_we        = 1'b1;
        tb_drv        = 1'b1;
        tb_wdata      = 32'h0000_FFFF;
        step();
        chk("abort grant", obs(), ef(1'b1, 1'b1, 1'b0, 1'b1));
        step();
        chk("abort access", obs(), ef(1'b1, 1'b0, 1'b0, 1'b1));
        reset = 1'b0;
        #1;
        chk("abort async clear", obs(), 5'b0);
        step();
        reset = 1'b1;
        drop_all();
        begin
            int stray;
            stray = 0;
            for (int c = 0; c < 8; c++) begin
                step();
                if (obs() != 5'b0) stray++;
            end
            chk("abort no stray response", 64'(stray), 64'd0);
        end
        run_txn('{1'b1, 1'b0, 32'h20, 32'h0, 32'h0000_1234}, "post-abort load");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
